// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared divide width, sequencer state encodings and hazard-vector index
//   DIV_WIDTH    : operand/result width of the divide unit
//   DIVSTALL_BIT : position of divstall in the hazard unit's stall vector
//   div_state_e  : IDLE -> BUSY -> DONE -> IDLE
package div_ctrl_pkg;
    localparam int DIV_WIDTH    = 32;
    localparam int DIVSTALL_BIT = 43;
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;
endpackage

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: EX-stage divide request and result bundle
//   master (EX/hazard side): drives div_startE, div_signedE, div_opaE, div_opbE, cancel, ext_stall
//                            receives div_stall, div_busy, div_valid, div_lo, div_hi
//   slave  (div_ctrl)      : mirror image
interface div_ctrl_if import div_ctrl_pkg::*; #(parameter int WIDTH = DIV_WIDTH);
    logic             div_startE;
    logic             div_signedE;
    logic [WIDTH-1:0] div_opaE;
    logic [WIDTH-1:0] div_opbE;
    logic             cancel;
    logic             ext_stall;
    logic             div_stall;
    logic             div_busy;
    logic             div_valid;
    logic [WIDTH-1:0] div_lo;
    logic [WIDTH-1:0] div_hi;
    modport master (
        output div_startE, div_signedE, div_opaE, div_opbE, cancel, ext_stall,
        input  div_stall, div_busy, div_valid, div_lo, div_hi
    );
    modport slave (
        input  div_startE, div_signedE, div_opaE, div_opbE, cancel, ext_stall,
        output div_stall, div_busy, div_valid, div_lo, div_hi
    );
endinterface

// File: rtl/div_ctrl_step.sv
// div_step: one combinational restoring shift-subtract iteration
//   i_rem/i_quo : partial remainder and quotient/dividend shift register
//   i_divisor   : divisor magnitude
//   o_rem/o_quo : values after one shift and conditional subtract
module div_step import div_ctrl_pkg::*; #(parameter int WIDTH = DIV_WIDTH) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);
    // One extra bit: the shifted remainder can exceed WIDTH bits when the divisor has its MSB set
    logic [WIDTH:0] w_shift;
    logic           w_ge;
    always_comb begin
        w_shift = {i_rem, i_quo[WIDTH-1]};
        w_ge    = w_shift >= {1'b0, i_divisor};
        o_rem   = w_ge ? WIDTH'(w_shift - {1'b0, i_divisor}) : w_shift[WIDTH-1:0];
        o_quo   = {i_quo[WIDTH-2:0], w_ge};
    end
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle DIV/DIVU sequencer for the EX stage
//   clk    : pipeline clock
//   resetn : asynchronous active-low reset
//   bus    : div_ctrl_if slave (request from EX, stall to hazard unit, LO/HI result for M)
module div_ctrl import div_ctrl_pkg::*; #(parameter int WIDTH = DIV_WIDTH) (
    input logic      clk,
    input logic      resetn,
    div_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    div_state_e       r_state, w_next;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rem, r_quo, r_divisor, r_lo, r_hi;
    logic [WIDTH-1:0] w_rem, w_quo;
    logic             r_sign_q, r_sign_r;
    logic             w_accept, w_last, w_neg_a, w_neg_b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_rem),
        .o_quo     (w_quo)
    );

    always_comb begin
        w_accept = (r_state == DIV_IDLE) && bus.div_startE && !bus.cancel;
        w_last   = (r_state == DIV_BUSY) && (r_count == CW'(WIDTH - 1)) && !bus.cancel;
        w_neg_a  = bus.div_signedE && bus.div_opaE[WIDTH-1];
        w_neg_b  = bus.div_signedE && bus.div_opbE[WIDTH-1];
        w_next   = r_state;
        case (r_state)
            DIV_IDLE: w_next = w_accept ? DIV_BUSY : DIV_IDLE;
            DIV_BUSY: w_next = bus.cancel ? DIV_IDLE : (w_last ? DIV_DONE : DIV_BUSY);
            DIV_DONE: w_next = (bus.cancel || !bus.ext_stall) ? DIV_IDLE : DIV_DONE;
            default:  w_next = DIV_IDLE;
        endcase
        // Combinational so the hazard unit already stalls in the accept cycle; DONE lets the instruction advance
        bus.div_stall = w_accept || ((r_state == DIV_BUSY) && !bus.cancel);
        bus.div_busy  = r_state != DIV_IDLE;
        bus.div_valid = r_state == DIV_DONE;
        bus.div_lo    = r_lo;
        bus.div_hi    = r_hi;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= DIV_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count   <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_lo      <= '0;
            r_hi      <= '0;
        end else begin
            if (w_accept) begin
                r_count   <= '0;
                r_rem     <= '0;
                r_quo     <= w_neg_a ? -bus.div_opaE : bus.div_opaE;
                r_divisor <= w_neg_b ? -bus.div_opbE : bus.div_opbE;
                r_sign_q  <= w_neg_a ^ w_neg_b;
                r_sign_r  <= w_neg_a;
            end else if (r_state == DIV_BUSY) begin
                r_count <= r_count + 1'b1;
                r_rem   <= w_rem;
                r_quo   <= w_quo;
            end
            // Result registers change only on completion so LO/HI hold through later divides and cancels
            if (w_last) begin
                r_lo <= r_sign_q ? -w_quo : w_quo;
                r_hi <= r_sign_r ? -w_rem : w_rem;
            end
        end
    end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed scoreboard bench for div_ctrl
module tb_div_ctrl;
    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          ncyc;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q[$];

    div_ctrl_if bus ();
    div_ctrl dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops on the first DONE cycle, checks hold length when valid falls
    initial begin
        exp_t cur;
        int   cyc = 0;
        logic prev = 1'b0;
        logic have = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.div_valid) begin
                if (!prev) begin
                    cyc = 0;
                    have = q.size() != 0;
                    if (have) cur = q.pop_front();
                    else begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_valid: got div_valid=1 expected no result at %0t", $time);
                    end
                end
                cyc++;
                if (have) begin
                    chk("lo", 64'(bus.div_lo), 64'(cur.lo));
                    chk("hi", 64'(bus.div_hi), 64'(cur.hi));
                    chk("stall_in_done", 64'(bus.div_stall), 64'd0);
                end
            end else if (prev && have) begin
                chk("valid_cycles", 64'(cyc), 64'(cur.ncyc));
            end
            prev = bus.div_valid;
        end
    end

    // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 of the next IDLE cycle
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] lo, input logic [31:0] hi, input int hold);
        int n;
        q.push_back('{lo: lo, hi: hi, ncyc: hold + 1});
        bus.div_startE  = 1'b1;
        bus.div_signedE = s;
        bus.div_opaE    = a;
        bus.div_opbE    = b;
        n = 0;
        @(negedge clk);
        chk("busy_at_accept", 64'(bus.div_busy), 64'd0);
        while (bus.div_stall && n < 100) begin
            n++;
            @(posedge clk);
            #1;
            bus.div_startE  = 1'b0;
            bus.div_signedE = ~s;
            bus.div_opaE    = $urandom;
            bus.div_opbE    = $urandom;
            @(negedge clk);
        end
        chk("stall_cycles", 64'(n), 64'd33);
        chk("valid_at_done", 64'(bus.div_valid), 64'd1);
        if (hold > 0) begin
            bus.ext_stall  = 1'b1;
            bus.div_startE = 1'b1;
            repeat (hold) begin
                @(posedge clk);
                #1;
            end
            bus.ext_stall  = 1'b0;
            bus.div_startE = 1'b0;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.div_startE  = 1'b0;
        bus.div_signedE = 1'b0;
        bus.div_opaE    = '0;
        bus.div_opbE    = '0;
        bus.cancel      = 1'b0;
        bus.ext_stall   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_stall", 64'(bus.div_stall), 64'd0);
        chk("rst_busy", 64'(bus.div_busy), 64'd0);
        chk("rst_valid", 64'(bus.div_valid), 64'd0);
        chk("rst_lo", 64'(bus.div_lo), 64'd0);
        chk("rst_hi", 64'(bus.div_hi), 64'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0);
        run_div(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd0, 32'd1, 32'hFFFF_FFF9, 0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 0);
        // cancel in IDLE overrides a start
        bus.div_startE = 1'b1;
        bus.cancel     = 1'b1;
        bus.div_opaE   = 32'd50;
        bus.div_opbE   = 32'd3;
        @(negedge clk);
        chk("idle_cancel_stall", 64'(bus.div_stall), 64'd0);
        @(posedge clk);
        #1;
        bus.cancel = 1'b0;
        @(negedge clk);
        chk("idle_cancel_busy", 64'(bus.div_busy), 64'd0);
        // cancel at BUSY iteration 10
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.div_startE = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.cancel = 1'b1;
        @(negedge clk);
        chk("busy_cancel_stall", 64'(bus.div_stall), 64'd0);
        chk("busy_cancel_busy", 64'(bus.div_busy), 64'd1);
        @(posedge clk);
        #1;
        bus.cancel = 1'b0;
        run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0);
        // DONE held by ext_stall with a start present, then back-to-back
        run_div(1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 3);
        run_div(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 0);
        // asynchronous reset mid-BUSY
        bus.div_startE  = 1'b1;
        bus.div_signedE = 1'b0;
        bus.div_opaE    = 32'd77;
        bus.div_opbE    = 32'd5;
        @(posedge clk);
        #1;
        bus.div_startE = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("arst_stall", 64'(bus.div_stall), 64'd0);
        chk("arst_busy", 64'(bus.div_busy), 64'd0);
        chk("arst_valid", 64'(bus.div_valid), 64'd0);
        chk("arst_lo", 64'(bus.div_lo), 64'd0);
        chk("arst_hi", 64'(bus.div_hi), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        run_div(1'b0, 32'd1, 32'd1, 32'd1, 32'd0, 0);
        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
